// File: rtl/key_cmd_decoder_pkg.sv
// ---------------------------------------------------------------------------
// key_cmd_decoder_pkg
//   Shared game definitions: PS/2 scan-code constants for the command keys
//   and prefixes, command indices, game state encodings and the PS/2
//   receiver state encoding.
//   No ports (package).
// ---------------------------------------------------------------------------
package key_cmd_decoder_pkg;

    // PS/2 set-2 prefixes
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;

    // Make codes of the mapped keys
    localparam logic [7:0] SC_H     = 8'h33;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_F     = 8'h2B;
    localparam logic [7:0] SC_C     = 8'h21;

    localparam int NUM_CMDS = 5;

    // Bit position of each command in the command / held vectors
    typedef enum logic [2:0] {
        CMD_HELP        = 3'd0,
        CMD_MENU        = 3'd1,
        CMD_SELECT_MAP  = 3'd2,
        CMD_GAME_FOREST = 3'd3,
        CMD_GAME_CASTLE = 3'd4
    } cmd_e;

    // Game state encodings used by the game controller
    typedef enum logic [2:0] {
        GS_MENU       = 3'd0,
        GS_HELP       = 3'd1,
        GS_MAP_SELECT = 3'd2,
        GS_FOREST     = 3'd3,
        GS_CASTLE     = 3'd4
    } game_state_e;

    // PS/2 frame receiver states
    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

    // Scan code that triggers the command at a given command index
    function automatic logic [7:0] cmd_scan_code(input int idx);
        logic [7:0] code;
        case (idx)
            0:       code = SC_H;
            1:       code = SC_ESC;
            2:       code = SC_ENTER;
            3:       code = SC_F;
            4:       code = SC_C;
            default: code = 8'h00;
        endcase
        return code;
    endfunction

    // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/key_cmd_decoder_ps2_rx.sv
// ---------------------------------------------------------------------------
// ps2_rx
//   PS/2 device-to-host frame receiver. Synchronises ps2_clk/ps2_data,
//   detects falling edges of ps2_clk, assembles 11-bit frames and checks
//   start, parity and stop bits plus an inactivity timeout.
//
//   clk        in   system clock
//   rst_n      in   synchronous active-low reset
//   ps2_clk    in   PS/2 clock (asynchronous)
//   ps2_data   in   PS/2 data  (asynchronous)
//   rx_byte    out  received byte, meaningful while byte_valid is high
//   byte_valid out  one-cycle strobe on the stop-bit edge of a good frame
//   frame_err  out  one-cycle strobe on start/parity/stop/timeout error
//
//   byte_valid and frame_err are strobes in the same cycle the stop-bit edge
//   is detected; the decoder registers them so its outputs appear exactly
//   one cycle after that detection.
// ---------------------------------------------------------------------------
module ps2_rx
    import key_cmd_decoder_pkg::*;
#(
    parameter int CLK_HZ     = 65_000_000,
    parameter int TIMEOUT_US = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int TIMEOUT_CYCLES = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int TW             = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    // [0],[1] form the synchroniser; [2] is the previous synchronised clock
    logic [2:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    data_sync_q, data_sync_d;
    rx_state_e     state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic fall;
    logic data_s;
    logic timeout;
    logic valid_c;
    logic err_c;

    assign fall   = clk_sync_q[2] & ~clk_sync_q[1];
    assign data_s = data_sync_q[1];

    // Timeout expires only while a frame is in progress and no edge arrives
    assign timeout = (state_q != RX_IDLE) && !fall && (tmo_q == TMO_LAST);

    always_comb begin
        clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        valid_c     = 1'b0;
        err_c       = 1'b0;

        if (state_q == RX_IDLE || fall) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        if (timeout) begin
            state_d = RX_IDLE;
            cnt_d   = 3'd0;
            shift_d = 8'h00;
            tmo_d   = '0;
            err_c   = 1'b1;
        end else if (fall) begin
            case (state_q)
                RX_IDLE: begin
                    if (!data_s) begin
                        state_d = RX_DATA;
                        cnt_d   = 3'd0;
                        shift_d = 8'h00;
                    end else begin
                        err_c = 1'b1;
                    end
                end
                RX_DATA: begin
                    // LSB arrives first, so shift in from the top
                    shift_d = {data_s, shift_q[7:1]};
                    if (cnt_q == 3'd7) begin
                        state_d = RX_PARITY;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                RX_PARITY: begin
                    parity_d = data_s;
                    state_d  = RX_STOP;
                end
                RX_STOP: begin
                    if (data_s && odd_parity_ok(shift_q, parity_q)) begin
                        valid_c = 1'b1;
                    end else begin
                        err_c = 1'b1;
                    end
                    state_d = RX_IDLE;
                    cnt_d   = 3'd0;
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Idle-high reset values avoid a false edge after release
            clk_sync_q  <= 3'b111;
            data_sync_q <= 2'b11;
            state_q     <= RX_IDLE;
            cnt_q       <= 3'd0;
            shift_q     <= 8'h00;
            parity_q    <= 1'b0;
            tmo_q       <= '0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            tmo_q       <= tmo_d;
        end
    end

    assign rx_byte    = shift_q;
    assign byte_valid = valid_c;
    assign frame_err  = err_c;

endmodule

// File: rtl/key_cmd_decoder.sv
// ---------------------------------------------------------------------------
// key_cmd_decoder
//   Turns PS/2 keyboard scan codes into one-cycle game command pulses.
//   Tracks the E0 (extended) and F0 (break) prefixes and a held bit per
//   mapped key so typematic repeats do not retrigger a command.
//
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset
//   ps2_clk      in   PS/2 clock (asynchronous)
//   ps2_data     in   PS/2 data  (asynchronous)
//   help         out  pulse on H make
//   menu         out  pulse on Esc make
//   select_map   out  pulse on Enter make
//   game_forest  out  pulse on F make
//   game_castle  out  pulse on C make
//   frame_err    out  pulse on any receive error
// ---------------------------------------------------------------------------
module key_cmd_decoder
    import key_cmd_decoder_pkg::*;
#(
    parameter int CLK_HZ     = 65_000_000,
    parameter int TIMEOUT_US = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic help,
    output logic menu,
    output logic select_map,
    output logic game_forest,
    output logic game_castle,
    output logic frame_err
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;

    ps2_rx #(
        .CLK_HZ     (CLK_HZ),
        .TIMEOUT_US (TIMEOUT_US)
    ) u_ps2_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .byte_valid (rx_valid),
        .frame_err  (rx_err)
    );

    logic [NUM_CMDS-1:0] key_hit;
    logic [NUM_CMDS-1:0] held_q, held_d;
    logic [NUM_CMDS-1:0] cmd_q, cmd_d;
    logic                ext_q, ext_d;
    logic                brk_q, brk_d;
    logic                frame_err_q, frame_err_d;

    // One comparator per mapped key; codes are distinct so at most one hits
    generate
        for (genvar gi = 0; gi < NUM_CMDS; gi++) begin : g_key_hit
            assign key_hit[gi] = (rx_byte == cmd_scan_code(gi));
        end
    endgenerate

    always_comb begin
        ext_d       = ext_q;
        brk_d       = brk_q;
        held_d      = held_q;
        cmd_d       = '0;
        frame_err_d = rx_err;

        if (rx_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (rx_valid) begin
            if (rx_byte == SC_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == SC_BRK) begin
                brk_d = 1'b1;
            end else begin
                // Evaluate with the current prefixes, then clear them
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (!ext_q) begin
                    for (int i = 0; i < NUM_CMDS; i++) begin
                        if (key_hit[i]) begin
                            if (brk_q) begin
                                held_d[i] = 1'b0;
                            end else if (!held_q[i]) begin
                                held_d[i] = 1'b1;
                                cmd_d[i]  = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            held_q      <= '0;
            cmd_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            held_q      <= held_d;
            cmd_q       <= cmd_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign help        = cmd_q[CMD_HELP];
    assign menu        = cmd_q[CMD_MENU];
    assign select_map  = cmd_q[CMD_SELECT_MAP];
    assign game_forest = cmd_q[CMD_GAME_FOREST];
    assign game_castle = cmd_q[CMD_GAME_CASTLE];
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_key_cmd_decoder.sv
// ---------------------------------------------------------------------------
// tb_key_cmd_decoder
//   Directed bench: drives PS/2 frames and checks cumulative pulse counts
//   of every output against hand-computed totals after each step.
//   Small CLK_HZ/TIMEOUT_US give a 20-cycle timeout.
// ---------------------------------------------------------------------------
module tb_key_cmd_decoder;

    localparam int HALF = 4;   // PS/2 half period in clk cycles

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic help, menu, select_map, game_forest, game_castle, frame_err;

    int n_cmp = 0;
    int n_mis = 0;

    // Index order: 0 help, 1 menu, 2 select_map, 3 game_forest, 4 game_castle, 5 frame_err
    int         high_cnt [6];
    int         rise_cnt [6];
    int         multi_cnt = 0;
    logic [5:0] prev_outs = 6'b0;
    logic [5:0] outs;

    key_cmd_decoder #(
        .CLK_HZ     (1_000_000),
        .TIMEOUT_US (20)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .help        (help),
        .menu        (menu),
        .select_map  (select_map),
        .game_forest (game_forest),
        .game_castle (game_castle),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 6; i++) begin
            high_cnt[i] = 0;
            rise_cnt[i] = 0;
        end
    end

    always @(negedge clk) begin
        outs = {frame_err, game_castle, game_forest, select_map, menu, help};
        for (int i = 0; i < 6; i++) begin
            if (outs[i] === 1'b1) begin
                high_cnt[i]++;
                if (prev_outs[i] !== 1'b1) rise_cnt[i]++;
            end
        end
        if ($countones(outs[4:0]) > 1) multi_cnt++;
        prev_outs = outs;
    end

    task automatic cmp(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Cumulative expected pulse counts; each pulse must be exactly one cycle wide
    task automatic check(input string tag, input int e_help, input int e_menu,
                         input int e_sel, input int e_forest, input int e_castle,
                         input int e_err);
        cmp({tag, ".help"},        high_cnt[0], e_help);
        cmp({tag, ".menu"},        high_cnt[1], e_menu);
        cmp({tag, ".select_map"},  high_cnt[2], e_sel);
        cmp({tag, ".game_forest"}, high_cnt[3], e_forest);
        cmp({tag, ".game_castle"}, high_cnt[4], e_castle);
        cmp({tag, ".frame_err"},   high_cnt[5], e_err);
        cmp({tag, ".help_rises"},   rise_cnt[0], e_help);
        cmp({tag, ".forest_rises"}, rise_cnt[3], e_forest);
        cmp({tag, ".err_rises"},    rise_cnt[5], e_err);
        cmp({tag, ".onehot"},       multi_cnt, 0);
        $display("step %s: help=%0d menu=%0d sel=%0d forest=%0d castle=%0d err=%0d",
                 tag, high_cnt[0], high_cnt[1], high_cnt[2], high_cnt[3],
                 high_cnt[4], high_cnt[5]);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip_par);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((~^b) ^ flip_par);
        send_bit(1'b1);
        ps2_data = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        cmp("rst.help",        int'(help), 0);
        cmp("rst.menu",        int'(menu), 0);
        cmp("rst.select_map",  int'(select_map), 0);
        cmp("rst.game_forest", int'(game_forest), 0);
        cmp("rst.game_castle", int'(game_castle), 0);
        cmp("rst.frame_err",   int'(frame_err), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset", 0, 0, 0, 0, 0, 0);

        // H make
        send_frame(8'h33, 1'b0);
        check("h_make", 1, 0, 0, 0, 0, 0);

        // F make, repeat, break, make again
        send_frame(8'h2B, 1'b0);
        check("f_make1", 1, 0, 0, 1, 0, 0);
        send_frame(8'h2B, 1'b0);
        check("f_repeat", 1, 0, 0, 1, 0, 0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h2B, 1'b0);
        check("f_break", 1, 0, 0, 1, 0, 0);
        send_frame(8'h2B, 1'b0);
        check("f_make2", 1, 0, 0, 2, 0, 0);

        // Extended Enter ignored, plain Enter fires
        send_frame(8'hE0, 1'b0);
        send_frame(8'h5A, 1'b0);
        check("ext_enter", 1, 0, 0, 2, 0, 0);
        send_frame(8'h5A, 1'b0);
        check("enter", 1, 0, 1, 2, 0, 0);

        // Esc with bad parity, then good
        send_frame(8'h76, 1'b1);
        check("esc_badpar", 1, 0, 1, 2, 0, 1);
        send_frame(8'h76, 1'b0);
        check("esc_good", 1, 1, 1, 2, 0, 1);

        // Timeout after start + 4 data bits
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        ps2_data = 1'b1;
        repeat (40) @(negedge clk);
        check("timeout", 1, 1, 1, 2, 0, 2);
        send_frame(8'h21, 1'b0);
        check("c_make", 1, 1, 1, 2, 1, 2);

        // Reset mid-frame: no error, held bits cleared so H fires again
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("mid_reset", 1, 1, 1, 2, 1, 2);
        send_frame(8'h33, 1'b0);
        check("h_after_rst", 2, 1, 1, 2, 1, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
